gray_sync_decoder: RTL and testbench
====================================

Name: gray_sync_decoder

Overview:
Downstream consumer of the parameterized Gray counter's gray_out bus. It synchronizes the Gray word into the local clk domain and decodes it to binary. It classifies every sampled change as a +1 step, a -1 step or an illegal multi-bit jump, and flags faults. It is used wherever a Gray count crosses a boundary or must be integrity-checked before use.

Parameters:
WIDTH, 4, width of the Gray input and binary output (>=2)
SYNC_STAGES, 2, number of synchronizer flops on gray_in (>=2)

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
gray_in  input  WIDTH  Gray code from the upstream counter; may be asynchronous to clk
clear  input  1  synchronous clear of sticky flags and error count
binary_out  output  WIDTH  decoded binary of the synchronized Gray value, registered
valid  output  1  high once binary_out holds a decoded sample (state TRACK)
step_up  output  1  one-cycle pulse: new value = previous + 1 mod 2^WIDTH
step_dn  output  1  one-cycle pulse: new value = previous - 1 mod 2^WIDTH
err  output  1  one-cycle pulse: more than one bit changed between consecutive samples
err_sticky  output  1  set by err, held until clear
bwd_sticky  output  1  set by step_dn, held until clear
err_count  output  8  saturating count of err pulses (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All synchronizer flops, prev_gray, binary_out and all outputs are 0.
  - state=INIT, init counter=0.
- Synchronizer:
  - gray_in passes through a chain of SYNC_STAGES flops; the last stage is gray_q.
  - Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
- State machine:
  - INIT: counts SYNC_STAGES cycles after reset release. Outputs stay 0 and no comparison is made. When the count is reached, go to PRIME.
  - PRIME: one cycle. Loads prev_gray<=gray_q and binary_out<=bin(gray_q); valid<=1. No step or err. Go to TRACK.
  - TRACK: each cycle, diff=gray_q^prev_gray; then prev_gray<=gray_q and binary_out<=bin(gray_q).
    - popcount(diff)=0: no pulse.
    - popcount(diff)=1: step_up if bin(gray_q)==binary_out+1 mod 2^WIDTH, else step_dn. Both are registered and fire on the same edge binary_out updates.
    - popcount(diff)>=2: err pulse and err_sticky<=1. binary_out still resynchronizes to the new value; the next comparison uses the new value.
  - TRACK is left only by reset.
- Latency: a gray_in change reaches binary_out and the pulses SYNC_STAGES+1 clk edges later.
- Wrap-around: Gray 1000 -> 0000 (WIDTH=4) is binary 15 -> 0 and counts as step_up. The reverse is step_dn.
- clear: synchronous; zeroes err_sticky, bwd_sticky and err_count. If a new err or step_dn occurs in the same cycle, set wins; err_count is then 1.
- The pulse outputs (step_up, step_dn, err) are mutually exclusive and never high outside TRACK.
- Reset mid-operation: immediate return to the reset values. The synchronizer is re-flushed through INIT; no pulse fires on the first post-reset sample.

Optional Feature:
Macro GRAY_SYNC_DECODER_ERRCNT_EN.
- Defined: 8-bit err_count increments on each err pulse, saturates at 255 and is cleared by clear or reset.
- Undefined: the counter logic is not built and err_count is tied to 8'd0. err and err_sticky are unaffected.

Test Plan:
- Reset release with gray_in=0000 held -> valid rises at edge 3; binary_out=0; no pulses.
- Upstream counter sequence 0000,0001,0011,0010 (one per cycle) -> binary_out 0,1,2,3 with a step_up per change, each 3 cycles after the gray_in edge.
- From binary 15 (gray 1000) drive 0000 -> binary_out=0, step_up=1, no err.
- Drive 0011 -> 0110 (2->4, two bits) -> err pulse, err_sticky=1, binary_out=4; a following 0111 gives step_up with no err.
- Drive 0010 -> 0011 (3->2) -> step_dn, bwd_sticky=1; assert clear the same cycle as a new err -> err_sticky stays 1 and err_count=1 (macro on) or 0 (macro off).
- Assert rst_n low mid-stream at binary 5 -> all outputs are 0 asynchronously; after release, valid returns after 3 edges with no step_up or err on the first sample.

Source files
------------

// File: rtl/gray_sync_decoder.sv
// ---------------------------------------------------------------------------
// gray_sync_decoder
//
// Purpose:
//   Receives a Gray-coded count from an upstream counter, which may run on an
//   unrelated clock, and brings it into the local clk domain through a
//   multi-flop synchronizer. The synchronized word is decoded to binary.
//   Every sampled change is classified as a +1 step, a -1 step, or an
//   illegal multi-bit jump. Faults are flagged as single-cycle pulses and in
//   sticky flags.
//
// Parameters:
//   WIDTH        width of the Gray input and binary output (>= 2)
//   SYNC_STAGES  number of synchronizer flops on gray_in (>= 2)
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   gray_in     in   Gray code from the upstream counter (may be async)
//   clear       in   synchronous clear of sticky flags and error count
//   binary_out  out  registered binary decode of the synchronized Gray value
//   valid       out  high once binary_out holds a decoded sample
//   step_up     out  one-cycle pulse, new value = previous + 1 (mod 2^WIDTH)
//   step_dn     out  one-cycle pulse, any other single-bit Gray change
//   err         out  one-cycle pulse, more than one Gray bit changed
//   err_sticky  out  set by err, held until clear
//   bwd_sticky  out  set by step_dn, held until clear
//   err_count   out  saturating 8-bit count of err pulses
//
// Optional feature:
//   GRAY_SYNC_DECODER_ERRCNT_EN -- when defined, err_count counts err pulses
//   and saturates at 255. When undefined, no counter is built and err_count
//   is tied to zero.
// ---------------------------------------------------------------------------
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clear,
  output logic [WIDTH-1:0] binary_out,
  output logic             valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             err,
  output logic             err_sticky,
  output logic             bwd_sticky,
  output logic [7:0]       err_count
);

  localparam int CNT_W = $clog2(SYNC_STAGES) + 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_PRIME,
    ST_TRACK
  } state_e;

  // Prefix-XOR from the MSB down turns a Gray word into binary.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchronizer chain; only the last stage is ever looked at.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] gray_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gray_q = sync_q[SYNC_STAGES-1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0] binary_q, binary_d;
  logic             valid_q, valid_d;
  logic             step_up_q, step_up_d;
  logic             step_dn_q, step_dn_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic             bwd_sticky_q, bwd_sticky_d;

  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] gray_bin;
  logic             one_bit;

  assign diff     = gray_q ^ prev_gray_q;
  assign gray_bin = gray2bin(gray_q);
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign one_bit  = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

  // Next-state and output decode. INIT gives the synchronizer time to flush
  // after reset, so the first real sample is never compared against the
  // zeroed prev_gray. PRIME loads the first sample without judging it.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    prev_gray_d = prev_gray_q;
    binary_d    = binary_q;
    valid_d     = valid_q;
    step_up_d   = 1'b0;
    step_dn_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_PRIME;
        end else begin
          init_cnt_d = init_cnt_q + CNT_W'(1);
        end
      end

      ST_PRIME: begin
        prev_gray_d = gray_q;
        binary_d    = gray_bin;
        valid_d     = 1'b1;
        state_d     = ST_TRACK;
      end

      ST_TRACK: begin
        // Always resynchronize, even after a bad jump, so the next
        // comparison is made against the value actually seen.
        prev_gray_d = gray_q;
        binary_d    = gray_bin;
        if (one_bit) begin
          if (gray_bin == binary_q + WIDTH'(1)) begin
            step_up_d = 1'b1;
          end else begin
            step_dn_d = 1'b1;
          end
        end else if (diff != '0) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    // A new event in the same cycle as clear wins over the clear.
    err_sticky_d = (err_sticky_q & ~clear) | err_d;
    bwd_sticky_d = (bwd_sticky_q & ~clear) | step_dn_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      prev_gray_q  <= '0;
      binary_q     <= '0;
      valid_q      <= 1'b0;
      step_up_q    <= 1'b0;
      step_dn_q    <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      bwd_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      prev_gray_q  <= prev_gray_d;
      binary_q     <= binary_d;
      valid_q      <= valid_d;
      step_up_q    <= step_up_d;
      step_dn_q    <= step_dn_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      bwd_sticky_q <= bwd_sticky_d;
    end
  end

`ifdef GRAY_SYNC_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating error counter; a clear coinciding with a new err leaves 1.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clear) begin
      err_cnt_d = {7'd0, err_d};
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign binary_out = binary_q;
  assign valid      = valid_q;
  assign step_up    = step_up_q;
  assign step_dn    = step_dn_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign bwd_sticky = bwd_sticky_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_gray_sync_decoder
//
// Self-checking bench for gray_sync_decoder. A reference model keeps the
// history of gray_in as seen at each clock edge since reset release. It
// derives every output from that history:
//   - binary_out after edge n is the decode of the sample from edge n-S.
//   - pulses compare that sample with the previous one.
// A compare process checks the DUT against the model on every cycle.
// Directed sequences add literal expectations that pin the model itself.
// The bench honours GRAY_SYNC_DECODER_ERRCNT_EN for the err_count checks.
// ---------------------------------------------------------------------------
module tb_gray_sync_decoder;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] grayIn = '0;

  logic [W-1:0] binaryOut;
  logic         valid;
  logic         stepUp;
  logic         stepDn;
  logic         err;
  logic         errSticky;
  logic         bwdSticky;
  logic [7:0]   errCount;

  int checkCount = 0;
  int passCount  = 0;

  gray_sync_decoder #(
    .WIDTH      (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (grayIn),
    .clear     (clear),
    .binary_out(binaryOut),
    .valid     (valid),
    .step_up   (stepUp),
    .step_dn   (stepDn),
    .err       (err),
    .err_sticky(errSticky),
    .bwd_sticky(bwdSticky),
    .err_count (errCount)
  );

  always #5 clk = ~clk;

  // Binary value of a Gray word is the XOR of all its right shifts.
  function automatic logic [W-1:0] toBin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < W; k++) begin
      b = b ^ (g >> k);
    end
    return b;
  endfunction

  function automatic logic [W-1:0] toGray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reference model state.
  int           edgeN = 0;
  logic [W-1:0] hist[$];
  logic [W-1:0] mBin = '0;
  logic         mValid = 1'b0;
  logic         mUp = 1'b0;
  logic         mDn = 1'b0;
  logic         mErr = 1'b0;
  logic         mErrSt = 1'b0;
  logic         mBwdSt = 1'b0;
  logic [7:0]   mCnt = 8'd0;
  logic [W-1:0] newG;
  logic [W-1:0] oldG;

  // The model advances on each clock edge from the input history alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edgeN  = 0;
      hist.delete();
      mBin   = '0;
      mValid = 1'b0;
      mUp    = 1'b0;
      mDn    = 1'b0;
      mErr   = 1'b0;
      mErrSt = 1'b0;
      mBwdSt = 1'b0;
      mCnt   = 8'd0;
    end else begin
      edgeN = edgeN + 1;
      hist.push_back(grayIn);
      mUp  = 1'b0;
      mDn  = 1'b0;
      mErr = 1'b0;
      if (edgeN >= S + 1) begin
        mValid = 1'b1;
        mBin   = toBin(hist[edgeN-S-1]);
      end
      if (edgeN >= S + 2) begin
        newG = hist[edgeN-S-1];
        oldG = hist[edgeN-S-2];
        if ($countones(newG ^ oldG) >= 2) begin
          mErr = 1'b1;
        end else if (newG != oldG) begin
          if (toBin(newG) == W'(toBin(oldG) + 1)) mUp = 1'b1;
          else mDn = 1'b1;
        end
      end
      mErrSt = (clear ? 1'b0 : mErrSt) | mErr;
      mBwdSt = (clear ? 1'b0 : mBwdSt) | mDn;
`ifdef GRAY_SYNC_DECODER_ERRCNT_EN
      if (clear) mCnt = {7'd0, mErr};
      else if (mErr && mCnt != 8'd255) mCnt = mCnt + 8'd1;
`else
      mCnt = 8'd0;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Drive one sample on the falling edge so it is stable at the next posedge.
  task automatic applyStimulus(input logic [W-1:0] g, input logic c);
    @(negedge clk);
    grayIn = g;
    clear  = c;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Per-cycle comparison against the model, sampled away from the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      checkOutput("model binary_out", binaryOut, mBin);
      checkOutput("model valid", valid, mValid);
      checkOutput("model step_up", stepUp, mUp);
      checkOutput("model step_dn", stepDn, mDn);
      checkOutput("model err", err, mErr);
      checkOutput("model err_sticky", errSticky, mErrSt);
      checkOutput("model bwd_sticky", bwdSticky, mBwdSt);
      checkOutput("model err_count", errCount, mCnt);
    end
  end

  logic [W-1:0] curB;
  int           r;

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput("reset valid", valid, 0);
    checkOutput("reset binary_out", binaryOut, 0);
    checkOutput("reset err_count", errCount, 0);

    // Reset release with gray 0000 held: valid rises at the third edge.
    rst_n = 1'b1;
    waitEdges(2);
    checkOutput("init valid low", valid, 0);
    waitEdges(1);
    checkOutput("prime valid", valid, 1);
    checkOutput("prime binary", binaryOut, 0);
    checkOutput("prime no step_up", stepUp, 0);
    checkOutput("prime no err", err, 0);

    // Upstream counter 0000,0001,0011,0010.
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0011, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    waitEdges(3);
    checkOutput("count binary 3", binaryOut, 3);
    checkOutput("count step_up", stepUp, 1);

    // Wrap 15 -> 0 is a step up.
    applyStimulus(4'b1000, 1'b0);
    waitEdges(4);
    checkOutput("binary 15", binaryOut, 15);
    applyStimulus(4'b0000, 1'b0);
    waitEdges(3);
    checkOutput("wrap binary 0", binaryOut, 0);
    checkOutput("wrap step_up", stepUp, 1);
    checkOutput("wrap no err", err, 0);

    // Two-bit jump 2 -> 4, then a legal step 4 -> 5.
    applyStimulus(4'b0011, 1'b0);
    waitEdges(4);
    applyStimulus(4'b0110, 1'b0);
    waitEdges(3);
    checkOutput("jump err", err, 1);
    checkOutput("jump err_sticky", errSticky, 1);
    checkOutput("jump binary 4", binaryOut, 4);
    applyStimulus(4'b0111, 1'b0);
    waitEdges(3);
    checkOutput("after jump step_up", stepUp, 1);
    checkOutput("after jump no err", err, 0);

    // Backward step 3 -> 2, then clear coinciding with a new err.
    applyStimulus(4'b0010, 1'b0);
    waitEdges(4);
    applyStimulus(4'b0011, 1'b0);
    waitEdges(3);
    checkOutput("back step_dn", stepDn, 1);
    checkOutput("back bwd_sticky", bwdSticky, 1);
    applyStimulus(4'b0110, 1'b0);
    applyStimulus(4'b0110, 1'b0);
    applyStimulus(4'b0110, 1'b1);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("clear+err err", err, 1);
    checkOutput("clear+err err_sticky", errSticky, 1);
    checkOutput("clear bwd_sticky", bwdSticky, 0);
`ifdef GRAY_SYNC_DECODER_ERRCNT_EN
    checkOutput("clear+err err_count", errCount, 1);
`else
    checkOutput("clear+err err_count", errCount, 0);
`endif

    // Reset in the middle of the stream at binary 5.
    applyStimulus(4'b0111, 1'b0);
    waitEdges(4);
    checkOutput("pre-reset binary 5", binaryOut, 5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset binary", binaryOut, 0);
    checkOutput("async reset valid", valid, 0);
    checkOutput("async reset err_sticky", errSticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitEdges(2);
    checkOutput("re-init valid low", valid, 0);
    waitEdges(1);
    checkOutput("re-prime valid", valid, 1);
    checkOutput("re-prime binary 5", binaryOut, 5);
    checkOutput("re-prime no step_up", stepUp, 0);
    checkOutput("re-prime no err", err, 0);

    // Random mix of counting, holds, jumps, clears and resets.
    curB = 4'd5;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35) curB = curB + 1'b1;
      else if (r < 55) curB = curB - 1'b1;
      else if (r >= 75) curB = W'($urandom);
      applyStimulus(toGray(curB), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // Sustained random jumps without clear drive err_count to saturation.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(W'($urandom), 1'b0);
    end
    applyStimulus(grayIn, 1'b0);
    waitEdges(4);
`ifdef GRAY_SYNC_DECODER_ERRCNT_EN
    checkOutput("saturated err_count", errCount, 255);
`else
    checkOutput("saturated err_count", errCount, 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
